// File: rtl/cpu_pkg.sv
// Shared datapath constants: opcodes, extender select encodings, fetch states, reset PC.
// Used by instr_fetch_latch and imm_ext_decode.
package cpu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [1:0] EXT_SIGN = 2'd0;
    localparam logic [1:0] EXT_ZERO = 2'd1;
    localparam logic [1:0] EXT_NONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imm_ext_decode.sv
// Combinational opcode lookup driving the immediate extender's select and enable.
module imm_ext_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [1:0] ext_sel,
    output logic       ext_en
);

    always_comb begin
        ext_sel = EXT_NONE;
        case (opcode)
            OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LW, OP_SB, OP_SW:  ext_sel = EXT_SIGN;
            OP_ANDI, OP_ORI, OP_XORI:    ext_sel = EXT_ZERO;
            default:                     ext_sel = EXT_NONE;
        endcase
    end

    assign ext_en = (ext_sel != EXT_NONE);

endmodule

// File: rtl/instr_fetch_latch.sv
// Fetch-and-hold stage: owns the PC, issues req/ack fetches, holds the word for the extender.
// Optional FETCH_TIMEOUT_EN adds a sticky fetch_err when mem_ack never arrives.
module instr_fetch_latch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [15:0] imm16,
    output logic [1:0]  ext_sel,
    output logic        ext_en,
    output logic        fetch_err
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  addr_reg, addr_next;
    logic [31:0]  instr_reg, instr_next;
    logic [31:0]  pc_out_reg, pc_out_next;
    logic         valid_reg, valid_next;
    logic         req_reg, req_next;
    logic         err_reg, err_next;
    logic         start_wait;
    logic         timeout_hit;
    logic [31:0]  redir_target;
    logic         transfer;

    assign redir_target = redirect_pc & ~32'h3;
    assign transfer     = valid_reg & instr_ready;

`ifdef FETCH_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [WAIT_W-1:0] wait_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_reg <= '0;
        end else if (start_wait) begin
            wait_reg <= '0;
        end else if (req_reg && !mem_ack) begin
            wait_reg <= wait_reg + 1'b1;
        end
    end

    // Fires on the last permitted wait cycle so mem_req drops right after it.
    assign timeout_hit = req_reg && !mem_ack && (wait_reg == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = start_wait | (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        instr_next  = instr_reg;
        pc_out_next = pc_out_reg;
        valid_next  = valid_reg;
        err_next    = err_reg;
        start_wait  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (redirect_valid) begin
                    pc_next = redir_target;
                end else if (fetch_en) begin
                    state_next = ST_REQ;
                    start_wait = 1'b1;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_next    = redir_target;
                    state_next = mem_ack ? ST_REQ : ST_DROP;
                    start_wait = 1'b1;
                end else if (mem_ack) begin
                    instr_next  = mem_rdata;
                    pc_out_next = pc_reg;
                    pc_next     = pc_reg + 32'd4;
                    valid_next  = 1'b1;
                    state_next  = ST_HOLD;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    valid_next = 1'b0;
                    pc_next    = redir_target;
                    state_next = ST_REQ;
                    start_wait = 1'b1;
                end else if (transfer) begin
                    valid_next = 1'b0;
                    state_next = fetch_en ? ST_REQ : ST_IDLE;
                    start_wait = fetch_en;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    pc_next = redir_target;
                end
                if (mem_ack) begin
                    state_next = ST_REQ;
                    start_wait = 1'b1;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The abandoned request in DROP keeps its old address until acked.
    assign req_next  = (state_next == ST_REQ) || (state_next == ST_DROP);
    assign addr_next = (state_next == ST_DROP) ? addr_reg : pc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_PC;
            addr_reg   <= RESET_PC;
            instr_reg  <= '0;
            pc_out_reg <= '0;
            valid_reg  <= 1'b0;
            req_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            addr_reg   <= addr_next;
            instr_reg  <= instr_next;
            pc_out_reg <= pc_out_next;
            valid_reg  <= valid_next;
            req_reg    <= req_next;
            err_reg    <= err_next;
        end
    end

    imm_ext_decode u_imm_ext_decode (
        .opcode  (instr_reg[31:26]),
        .ext_sel (ext_sel),
        .ext_en  (ext_en)
    );

    assign mem_req     = req_reg;
    assign mem_addr    = addr_reg;
    assign instr_valid = valid_reg;
    assign instr       = instr_reg;
    assign pc_out      = pc_out_reg;
    assign imm16       = instr_reg[15:0];
    assign fetch_err   = err_reg;

endmodule

// File: tb/tb_instr_fetch_latch.sv
// Self-checking bench for instr_fetch_latch: directed scenarios plus randomized traffic
// against a transaction-level reference model. Define FETCH_TIMEOUT_EN to exercise the timeout.
module tb_instr_fetch_latch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [15:0] imm16;
    logic [1:0]  ext_sel;
    logic        ext_en;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } item_t;

    logic [5:0] sign_ops [10] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h20, 6'h23, 6'h28, 6'h2B};
    logic [5:0] zero_ops [3]  = '{6'h0C, 6'h0D, 6'h0E};
    logic [5:0] op_pool  [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                  6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h28, 6'h2B, 6'h3F};

    always #5 clk = ~clk;

`ifdef FETCH_TIMEOUT_EN
    instr_fetch_latch #(.TIMEOUT_CYCLES(4)) dut (
`else
    instr_fetch_latch dut (
`endif
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc_out         (pc_out),
        .imm16          (imm16),
        .ext_sel        (ext_sel),
        .ext_en         (ext_en),
        .fetch_err      (fetch_err)
    );

    function automatic logic [1:0] ext_ref(input logic [5:0] op);
        foreach (sign_ops[i]) if (sign_ops[i] == op) return 2'd0;
        foreach (zero_ops[i]) if (zero_ops[i] == op) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if ($urandom_range(0, 3) != 0) w[31:26] = op_pool[$urandom_range(0, 17)];
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        fetch_en = 1'b0; mem_ack = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0 || fetch_err !== 1'b0)
            begin errors++; $display("FAIL reset_ctrl: got req=%b addr=%h valid=%b err=%b required 0/00000000/0/0", mem_req, mem_addr, instr_valid, fetch_err); end
        checks++;
        if (instr !== 32'h0 || pc_out !== 32'h0 || imm16 !== 16'h0 || ext_sel !== 2'd2 || ext_en !== 1'b0)
            begin errors++; $display("FAIL reset_data: got instr=%h pc_out=%h imm16=%h ext_sel=%0d ext_en=%b required 0/0/0/2/0", instr, pc_out, imm16, ext_sel, ext_en); end
        rst_n = 1'b1;
        $display("reset checked");
    endtask

    task automatic test_first_fetch();
        fetch_en = 1'b1; instr_ready = 1'b1;
        cyc();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0)
            begin errors++; $display("FAIL first_req: got req=%b addr=%h required 1/00000000", mem_req, mem_addr); end
        cyc();
        cyc();
        checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b1)
            begin errors++; $display("FAIL first_wait: got valid=%b req=%b required 0/1", instr_valid, mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'h2008FFFF;
        cyc();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h2008FFFF || imm16 !== 16'hFFFF || ext_sel !== 2'd0 || ext_en !== 1'b1 || pc_out !== 32'h0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL first_hold: got valid=%b instr=%h imm16=%h ext_sel=%0d ext_en=%b pc_out=%h req=%b required 1/2008ffff/ffff/0/1/00000000/0", instr_valid, instr, imm16, ext_sel, ext_en, pc_out, mem_req); end
        cyc();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h4 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL first_next: got req=%b addr=%h valid=%b required 1/00000004/0", mem_req, mem_addr, instr_valid); end
        $display("fetch addr=00000000 instr=2008ffff delivered");
    endtask

    task automatic test_decode();
        mem_ack = 1'b1; mem_rdata = 32'h3408ABCD;
        cyc();
        mem_ack = 1'b0;
        checks++;
        if (ext_sel !== 2'd1 || ext_en !== 1'b1 || imm16 !== 16'hABCD || pc_out !== 32'h4)
            begin errors++; $display("FAIL decode_ori: got ext_sel=%0d ext_en=%b imm16=%h pc_out=%h required 1/1/abcd/00000004", ext_sel, ext_en, imm16, pc_out); end
        cyc();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8)
            begin errors++; $display("FAIL decode_next: got req=%b addr=%h required 1/00000008", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h3C010010; instr_ready = 1'b0;
        cyc();
        mem_ack = 1'b0;
        checks++;
        if (ext_sel !== 2'd2 || ext_en !== 1'b0 || imm16 !== 16'h0010 || pc_out !== 32'h8)
            begin errors++; $display("FAIL decode_lui: got ext_sel=%0d ext_en=%b imm16=%h pc_out=%h required 2/0/0010/00000008", ext_sel, ext_en, imm16, pc_out); end
        $display("fetch ori/lui decode done");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h3C010010 || mem_req !== 1'b0 || pc_out !== 32'h8)
                begin errors++; $display("FAIL stall_hold%0d: got valid=%b instr=%h req=%b pc_out=%h required 1/3c010010/0/00000008", i, instr_valid, instr, mem_req, pc_out); end
        end
        fetch_en = 1'b0; instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL stall_release: got valid=%b req=%b required 0/0", instr_valid, mem_req); end
        $display("stall of 5 cycles done");
    endtask

    task automatic test_redirect_drop();
        fetch_en = 1'b1;
        cyc();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hC)
            begin errors++; $display("FAIL drop_req: got req=%b addr=%h required 1/0000000c", mem_req, mem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'hC || instr_valid !== 1'b0)
                begin errors++; $display("FAIL drop_old%0d: got req=%b addr=%h valid=%b required 1/0000000c/0", i, mem_req, mem_addr, instr_valid); end
            if (i < 2) cyc();
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        cyc();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100)
            begin errors++; $display("FAIL drop_discard: got valid=%b req=%b addr=%h required 0/1/00000100", instr_valid, mem_req, mem_addr); end
        fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h24420001;
        cyc();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h24420001 || pc_out !== 32'h100 || ext_sel !== 2'd0)
            begin errors++; $display("FAIL drop_after: got valid=%b instr=%h pc_out=%h ext_sel=%0d required 1/24420001/00000100/0", instr_valid, instr, pc_out, ext_sel); end
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        $display("redirect during request: deadbeef dropped, 24420001 delivered at 00000100");
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        cyc();
        redirect_valid = 1'b0; fetch_en = 1'b1;
        cyc();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC)
            begin errors++; $display("FAIL wrap_req: got req=%b addr=%h required 1/fffffffc", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h8C000000; instr_ready = 1'b1;
        cyc();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== 32'hFFFF_FFFC || ext_sel !== 2'd0)
            begin errors++; $display("FAIL wrap_hold: got valid=%b pc_out=%h ext_sel=%0d required 1/fffffffc/0", instr_valid, pc_out, ext_sel); end
        cyc();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0)
            begin errors++; $display("FAIL wrap_next: got req=%b addr=%h required 1/00000000", mem_req, mem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h103; mem_ack = 1'b1; mem_rdata = 32'h11111111;
        cyc();
        redirect_valid = 1'b0; mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL redir_ack: got req=%b addr=%h valid=%b required 1/00000100/0", mem_req, mem_addr, instr_valid); end
        fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h00000020;
        cyc();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h100 || ext_sel !== 2'd2 || ext_en !== 1'b0)
            begin errors++; $display("FAIL redir_ack_data: got valid=%b pc_out=%h ext_sel=%0d ext_en=%b required 1/00000100/2/0", instr_valid, pc_out, ext_sel, ext_en); end
        cyc();
        instr_ready = 1'b0;
        $display("wrap fffffffc->00000000 and redirect 103->100 done");
    endtask

    task automatic test_async_reset();
        fetch_en = 1'b1;
        cyc();
        checks++;
        if (mem_req !== 1'b1)
            begin errors++; $display("FAIL areset_pre: got req=%b required 1", mem_req); end
        fetch_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL areset_drop: got req=%b addr=%h valid=%b required 0/00000000/0", mem_req, mem_addr, instr_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("async reset mid-request done");
    endtask

    task automatic test_timeout();
        fetch_en = 1'b1;
        cyc();
        fetch_en = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 3; i++) cyc();
        checks++;
        if (mem_req !== 1'b1 || fetch_err !== 1'b0)
            begin errors++; $display("FAIL tmo_early: got req=%b err=%b required 1/0", mem_req, fetch_err); end
        cyc();
        checks++;
        if (mem_req !== 1'b0 || fetch_err !== 1'b1 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL tmo_fire: got req=%b err=%b valid=%b required 0/1/0", mem_req, fetch_err, instr_valid); end
        cyc();
        checks++;
        if (mem_req !== 1'b0 || fetch_err !== 1'b1)
            begin errors++; $display("FAIL tmo_sticky: got req=%b err=%b required 0/1", mem_req, fetch_err); end
        fetch_en = 1'b1;
        cyc();
        fetch_en = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0 || fetch_err !== 1'b1)
            begin errors++; $display("FAIL tmo_retry: got req=%b addr=%h err=%b required 1/00000000/1", mem_req, mem_addr, fetch_err); end
`else
        for (int i = 0; i < 300; i++) cyc();
        checks++;
        if (mem_req !== 1'b1 || fetch_err !== 1'b0)
            begin errors++; $display("FAIL no_tmo: got req=%b err=%b required 1/0", mem_req, fetch_err); end
`endif
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fetch_err !== 1'b0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL tmo_clear: got err=%b req=%b required 0/0", fetch_err, mem_req); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("timeout scenario done");
    endtask

    task automatic test_random();
        item_t       q[$];
        logic [31:0] exp_pc, req_addr;
        logic        req_active, tainted, exp_req, next_req;
        logic [1:0]  es;
        int          lat, delivered;
        do_reset();
        exp_pc = 32'h0; req_addr = 32'h0; req_active = 1'b0; tainted = 1'b0; exp_req = 1'b0;
        lat = 0; delivered = 0;
        for (int n = 0; n < 4000; n++) begin
            checks++;
            if (instr_valid !== (q.size() != 0))
                begin errors++; $display("FAIL rand_valid@%0d: got %b required %b", n, instr_valid, q.size() != 0); end
            if (q.size() != 0) begin
                es = ext_ref(q[0].word[31:26]);
                checks++;
                if (instr !== q[0].word || pc_out !== q[0].addr || imm16 !== q[0].word[15:0] || ext_sel !== es || ext_en !== (es != 2'd2))
                    begin errors++; $display("FAIL rand_data@%0d: got instr=%h pc_out=%h imm16=%h ext_sel=%0d ext_en=%b required %h/%h/%h/%0d/%b", n, instr, pc_out, imm16, ext_sel, ext_en, q[0].word, q[0].addr, q[0].word[15:0], es, es != 2'd2); end
            end
            checks++;
            if (mem_req !== exp_req)
                begin errors++; $display("FAIL rand_req@%0d: got %b required %b", n, mem_req, exp_req); end
            if (mem_req === 1'b1) begin
                checks++;
                if (!req_active) begin
                    req_active = 1'b1; req_addr = mem_addr; tainted = 1'b0; lat = $urandom_range(0, 3);
                    if (mem_addr !== exp_pc)
                        begin errors++; $display("FAIL rand_addr@%0d: got %h required %h", n, mem_addr, exp_pc); end
                end else if (mem_addr !== req_addr)
                    begin errors++; $display("FAIL rand_addr_hold@%0d: got %h required %h", n, mem_addr, req_addr); end
            end

            fetch_en       = ($urandom_range(0, 7) != 0);
            instr_ready    = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom();
            mem_rdata      = rand_word();
            if (req_active) begin
                mem_ack = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                mem_ack = ($urandom_range(0, 7) == 0);
            end

            next_req = 1'b0;
            if (redirect_valid) begin
                exp_pc = redirect_pc & ~32'h3;
                if (req_active) tainted = 1'b1;
            end
            if (q.size() != 0) begin
                if (instr_ready) begin
                    delivered++;
                    $display("deliver addr=%h instr=%h", q[0].addr, q[0].word);
                    void'(q.pop_front());
                    next_req = redirect_valid ? 1'b1 : fetch_en;
                end else if (redirect_valid) begin
                    void'(q.pop_front());
                    next_req = 1'b1;
                end
            end else if (req_active) begin
                if (mem_ack) begin
                    req_active = 1'b0;
                    if (tainted) begin
                        next_req = 1'b1;
                    end else begin
                        q.push_back('{addr: req_addr, word: mem_rdata});
                        exp_pc = req_addr + 32'd4;
                    end
                end else begin
                    next_req = 1'b1;
                end
            end else begin
                next_req = redirect_valid ? 1'b0 : fetch_en;
            end
            exp_req = next_req;
            cyc();
        end
        clear_inputs();
        checks++;
        if (delivered < 100)
            begin errors++; $display("FAIL rand_progress: got %0d deliveries required at least 100", delivered); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_decode();
        test_stall();
        test_redirect_drop();
        test_wrap();
        test_async_reset();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_latch.md
Name: instr_fetch_latch

Overview:
Fetch-and-hold stage directly upstream of the 16-bit immediate sign/zero extender in the multicycle MIPS-style datapath. Owns the PC and issues one-at-a-time requests to instruction memory over a req/ack handshake. Latches the returned word and presents it downstream over valid/ready. Decodes the opcode into the extender's imm16 and ext_sel/ext_en inputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned).
TIMEOUT_CYCLES, 255, cycles allowed for mem_ack before fetch_err (only with FETCH_TIMEOUT_EN).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
fetch_en  in  1  permits leaving IDLE / issuing a new request.
mem_req  out  1  instruction-memory request, held until mem_ack.
mem_addr  out  32  fetch address (= pc), stable while mem_req=1.
mem_ack  in  1  memory returns mem_rdata this cycle.
mem_rdata  in  32  instruction word.
redirect_valid  in  1  branch/jump redirect, single-cycle pulse.
redirect_pc  in  32  redirect target (bits[1:0] ignored, forced 0).
instr_valid  out  1  instr/imm16/ext_sel valid.
instr_ready  in  1  downstream accepts; transfer = instr_valid & instr_ready.
instr  out  32  latched instruction.
pc_out  out  32  address of latched instruction.
imm16  out  16  instr[15:0].
ext_sel  out  2  0 = sign-extend, 1 = zero-extend, 2 = no immediate.
ext_en  out  1  1 when ext_sel != 2.
fetch_err  out  1  sticky timeout flag (0 when FETCH_TIMEOUT_EN undefined).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, pc_out=0, imm16=0, ext_sel=2, ext_en=0, fetch_err=0.
- States: IDLE, REQ, HOLD, DROP. All outputs registered, except that imm16/ext_sel/ext_en are pure functions of the registered instr.
- IDLE: when fetch_en=1, go to REQ next cycle with mem_req=1.
- REQ: mem_req=1, mem_addr=pc.
  - On mem_ack: instr<=mem_rdata, pc_out<=pc, pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0), instr_valid<=1, go to HOLD.
  - Minimum latency: 1 cycle from mem_ack to instr_valid.
- HOLD: instr_valid=1, outputs frozen.
  - On transfer: if fetch_en=1, go to REQ (back-to-back, mem_req rises the cycle after the transfer); otherwise go to IDLE. instr_valid<=0 in both cases.
- Redirect (priority over all other events):
  - IDLE: pc<=redirect_pc, stay in IDLE.
  - REQ without mem_ack: pc<=redirect_pc, go to DROP. The request is kept high at the old address until acked.
  - REQ with mem_ack the same cycle: data discarded, pc<=redirect_pc, go to REQ.
  - HOLD: instr_valid<=0, pc<=redirect_pc, go to REQ. A simultaneous transfer still counts as delivered.
- DROP: mem_req=1 at the old address. On mem_ack, discard the data and go to REQ with the redirected pc. A further redirect while in DROP overwrites pc.
- ext_sel decode on instr[31:26]:
  - 0 (sign-extend): 0x04, 0x05, 0x08, 0x09, 0x0A, 0x0B, 0x20, 0x23, 0x28, 0x2B.
  - 1 (zero-extend): 0x0C, 0x0D, 0x0E.
  - 2 (no immediate): everything else, including 0x00, 0x02, 0x03, 0x0F.
- mem_ack outside REQ/DROP is ignored.
- Reset mid-request drops mem_req immediately (asynchronous).

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined: an 8+ bit wait counter clears on entry to REQ/DROP and increments each cycle mem_req=1 && mem_ack=0. Reaching TIMEOUT_CYCLES sets fetch_err (sticky until reset), forces mem_req=0, and returns to IDLE. The pc stays at the failed address.
- Undefined: no counter is built; fetch_err is tied to 0 and the block waits indefinitely.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (OP_ADDI=6'h08 … OP_SW=6'h2B);
  - ext_sel encodings EXT_SIGN=2'd0, EXT_ZERO=2'd1, EXT_NONE=2'd2;
  - fetch-state encoding;
  - RESET_PC default.
- One natural sub-module: imm_ext_decode, a combinational opcode-to-{ext_sel, ext_en} lookup, shared with the main decoder.

Test Plan:
- Reset then fetch_en=1, memory acks after 2 cycles with 0x2008FFFF, instr_ready=1 -> mem_addr=0x0, instr_valid 1 cycle after ack; imm16=0xFFFF, ext_sel=0, ext_en=1, pc_out=0, next mem_addr=0x4.
- Fetch 0x3408ABCD (ori) then 0x3C010010 (lui) -> ext_sel=1/ext_en=1, then ext_sel=2/ext_en=0.
- Hold instr_ready=0 for 5 cycles in HOLD -> instr and instr_valid stable, mem_req=0, no PC advance.
- redirect_valid with redirect_pc=0x100 while REQ is pending, ack 3 cycles later carrying 0xDEADBEEF -> word discarded, instr_valid stays 0, next mem_addr=0x100.
- pc=0xFFFFFFFC fetch -> next mem_addr=0x00000000; redirect_pc=0x103 -> mem_addr=0x100.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, never ack -> fetch_err=1 after 4 wait cycles, mem_req=0, state IDLE; async rst_n pulse clears fetch_err.
